// File: rtl/slave_in_port.sv
// Slave-side serial bus receiver: deserialises address, write data and burst
// length, then presents write/read requests to the slave core over valid/ready.
module slave_in_port #(
  parameter int unsigned SLAVE_ADDR_SIZE = 12,
  parameter int unsigned WORD_SIZE       = 8,
  parameter int unsigned BURST_SIZE      = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       slave_select,
  input  logic                       addr_bus,
  input  logic                       w_data_bus,
  input  logic                       burst_size_bus,
  input  logic                       read_en,
  input  logic                       m_valid,
  input  logic                       m_b_tx_valid,
  input  logic                       split_on,
  input  logic                       core_ready,
  output logic                       s_ready,
  output logic [SLAVE_ADDR_SIZE-1:0] core_addr,
  output logic [WORD_SIZE-1:0]       core_wdata,
  output logic                       core_wr,
  output logic                       core_rd,
  output logic [BURST_SIZE-1:0]      core_burst_len,
  output logic                       rx_busy
);

  localparam int unsigned CNT_MAX_A = (SLAVE_ADDR_SIZE > WORD_SIZE) ? SLAVE_ADDR_SIZE : WORD_SIZE;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > BURST_SIZE) ? CNT_MAX_A : BURST_SIZE;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR_RX, DECODE, BURST_RX, RD_ISSUE, DATA_RX, WR_HOLD
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]       shreg_q, shreg_d;
  logic                       s_ready_d;
  logic [SLAVE_ADDR_SIZE-1:0] core_addr_d;
  logic [WORD_SIZE-1:0]       core_wdata_d;
  logic                       core_wr_d;
  logic                       core_rd_d;
  logic [BURST_SIZE-1:0]      core_burst_len_d;
  logic                       rx_busy_d;
  logic [WORD_SIZE-1:0]       word_c;
  logic [SLAVE_ADDR_SIZE-1:0] addr_shift_c;
  logic [BURST_SIZE-1:0]      blen_shift_c;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shreg_q        <= '0;
      s_ready        <= 1'b0;
      core_addr      <= '0;
      core_wdata     <= '0;
      core_wr        <= 1'b0;
      core_rd        <= 1'b0;
      core_burst_len <= '0;
      rx_busy        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shreg_q        <= shreg_d;
      s_ready        <= s_ready_d;
      core_addr      <= core_addr_d;
      core_wdata     <= core_wdata_d;
      core_wr        <= core_wr_d;
      core_rd        <= core_rd_d;
      core_burst_len <= core_burst_len_d;
      rx_busy        <= rx_busy_d;
    end
  end

  // Serial fields arrive LSB first, so each new bit enters at the MSB and shifts down
  always_comb begin
    word_c       = {w_data_bus, shreg_q[WORD_SIZE-1:1]};
    addr_shift_c = {addr_bus, core_addr[SLAVE_ADDR_SIZE-1:1]};
    blen_shift_c = {burst_size_bus, core_burst_len[BURST_SIZE-1:1]};
  end

  // Next-state and next-output logic
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    shreg_d          = shreg_q;
    s_ready_d        = s_ready;
    core_addr_d      = core_addr;
    core_wdata_d     = core_wdata;
    core_wr_d        = core_wr;
    core_rd_d        = core_rd;
    core_burst_len_d = core_burst_len;

    if (state_q != IDLE && split_on) begin
      state_d   = IDLE;
      cnt_d     = '0;
      shreg_d   = '0;
      core_wr_d = 1'b0;
      core_rd_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          s_ready_d = 1'b1;
          cnt_d     = '0;
          if (slave_select) state_d = ADDR_RX;
        end
        ADDR_RX: begin
          if (!slave_select) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            core_addr_d = addr_shift_c;
            if (cnt_q == CNT_W'(SLAVE_ADDR_SIZE - 1)) begin
              state_d = DECODE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DECODE: begin
          cnt_d = '0;
          if (!slave_select) begin
            state_d = IDLE;
          end else if (read_en && m_b_tx_valid) begin
            state_d = BURST_RX;
          end else if (read_en) begin
            core_burst_len_d = BURST_SIZE'(1);
            core_rd_d        = 1'b1;
            state_d          = RD_ISSUE;
          end else begin
            shreg_d = '0;
            state_d = DATA_RX;
          end
        end
        BURST_RX: begin
          if (!slave_select) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (m_b_tx_valid) begin
            core_burst_len_d = blen_shift_c;
            if (cnt_q == CNT_W'(BURST_SIZE - 1)) begin
              core_rd_d = 1'b1;
              state_d   = RD_ISSUE;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        RD_ISSUE: begin
          if (core_rd && core_ready) begin
            core_rd_d = 1'b0;
            state_d   = IDLE;
          end
        end
        DATA_RX: begin
          if (!slave_select) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
          end else if (m_valid) begin
            shreg_d = word_c;
            if (cnt_q == CNT_W'(WORD_SIZE - 1)) begin
              core_wdata_d = word_c;
              core_wr_d    = 1'b1;
              s_ready_d    = 1'b0;
              state_d      = WR_HOLD;
              cnt_d        = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        WR_HOLD: begin
          if (core_wr && core_ready) begin
            core_wr_d   = 1'b0;
            core_addr_d = core_addr + SLAVE_ADDR_SIZE'(1);
            s_ready_d   = 1'b1;
            state_d     = slave_select ? DATA_RX : IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    rx_busy_d = (state_d != IDLE);
  end

endmodule
